// File: rtl/model_sweep_ctrl.sv
// Sweeps an msdsl model through configurations: reset, settle, sample, hand off.
// Tracks the signed min/max of the samples taken in the current sweep.
module model_sweep_ctrl #(
  parameter int G_WIDTH    = 25,
  parameter int CFG_W      = 4,
  parameter int SETTLE_W   = 16,
  parameter int RST_CYCLES = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       abort,
  input  logic [CFG_W-1:0]           cfg_count,
  input  logic [SETTLE_W-1:0]        settle_cycles,
  input  logic signed [G_WIDTH-1:0]  g_in,
  output logic                       model_rst,
  output logic [CFG_W-1:0]           cfg_idx,
  output logic                       busy,
  output logic                       done,
  output logic                       sample_valid,
  input  logic                       sample_ready,
  output logic signed [G_WIDTH-1:0]  sample_data,
  output logic [CFG_W-1:0]           sample_idx,
  output logic signed [G_WIDTH-1:0]  g_min,
  output logic signed [G_WIDTH-1:0]  g_max
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET,
    S_SETTLE,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [SETTLE_W-1:0] RST_LAST =
    SETTLE_W'(RST_CYCLES - 1);

  state_t              state;
  state_t              state_n;
  logic [CFG_W-1:0]    n_lat;
  logic [SETTLE_W-1:0] s_lat;
  logic [SETTLE_W-1:0] cnt;
  logic                seen;
  logic                rst_end;
  logic                set_end;
  logic                hs;
  logic                last;

  assign rst_end = (cnt == RST_LAST);
  assign set_end = (cnt == s_lat);
  assign hs      = sample_valid && sample_ready;
  assign last    = (cfg_idx == n_lat - CFG_W'(1));

  always_comb begin
    state_n   = state;
    model_rst = 1'b1;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start)
          state_n = (cfg_count == '0) ? S_DONE : S_RESET;
      end
      S_RESET: begin
        busy = 1'b1;
        if (abort)        state_n = S_IDLE;
        else if (rst_end) state_n = S_SETTLE;
      end
      S_SETTLE: begin
        busy      = 1'b1;
        model_rst = 1'b0;
        if (abort)        state_n = S_IDLE;
        else if (set_end) state_n = S_WAIT;
      end
      S_WAIT: begin
        busy      = 1'b1;
        model_rst = 1'b0;
        if (abort)   state_n = S_IDLE;
        else if (hs) state_n = last ? S_DONE : S_RESET;
      end
      S_DONE: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      n_lat        <= '0;
      s_lat        <= '0;
      seen         <= 1'b0;
      cfg_idx      <= '0;
      sample_valid <= 1'b0;
      sample_data  <= '0;
      sample_idx   <= '0;
      g_min        <= '0;
      g_max        <= '0;
    end else begin
      state <= state_n;
      if (state_n != state)
        cnt <= '0;
      else if (state == S_RESET || state == S_SETTLE)
        cnt <= cnt + SETTLE_W'(1);
      if (state == S_IDLE && start) begin
        n_lat   <= cfg_count;
        s_lat   <= settle_cycles;
        seen    <= 1'b0;
        cfg_idx <= '0;
      end
      if (state == S_SETTLE && !abort && set_end) begin
        sample_data  <= g_in;
        sample_idx   <= cfg_idx;
        sample_valid <= 1'b1;
      end
      if (state == S_WAIT) begin
        if (abort) begin
          sample_valid <= 1'b0;
        end else if (hs) begin
          sample_valid <= 1'b0;
          seen         <= 1'b1;
          // First sample of a sweep seeds both extremes
          if (!seen || sample_data < g_min) g_min <= sample_data;
          if (!seen || sample_data > g_max) g_max <= sample_data;
          if (!last) cfg_idx <= cfg_idx + CFG_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_model_sweep_ctrl.sv
// Bench for model_sweep_ctrl: procedural per-configuration schedule model.
// Random g_in / ready, directed aborts, async reset and edge sweeps.
module tb_model_sweep_ctrl;

  localparam int GW = 25;
  localparam int CW = 4;
  localparam int SW = 16;
  localparam int RC = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic sample_ready = 1'b0;
  logic [CW-1:0] cfg_count = '0;
  logic [SW-1:0] settle_cycles = '0;
  logic signed [GW-1:0] g_in = '0;
  logic model_rst;
  logic busy;
  logic done;
  logic sample_valid;
  logic [CW-1:0] cfg_idx;
  logic [CW-1:0] sample_idx;
  logic signed [GW-1:0] sample_data;
  logic signed [GW-1:0] g_min;
  logic signed [GW-1:0] g_max;

  int n_chk = 0;
  int n_pass = 0;
  int mn = 0;
  int mx = 0;
  bit seen = 0;
  int gq[$];

  always #5 clk = ~clk;

  model_sweep_ctrl #(
    .G_WIDTH(GW), .CFG_W(CW), .SETTLE_W(SW), .RST_CYCLES(RC)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_count(cfg_count), .settle_cycles(settle_cycles),
    .g_in(g_in), .model_rst(model_rst), .cfg_idx(cfg_idx),
    .busy(busy), .done(done), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .sample_data(sample_data),
    .sample_idx(sample_idx), .g_min(g_min), .g_max(g_max)
  );

  task automatic chk(string tag, int got, int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", tag, got, exp);
  endtask

  task automatic idle_chk(string t);
    chk({t, "_busy"}, busy, 0);
    chk({t, "_done"}, done, 0);
    chk({t, "_mrst"}, model_rst, 1);
    chk({t, "_valid"}, sample_valid, 0);
    chk({t, "_gmin"}, g_min, mn);
    chk({t, "_gmax"}, g_max, mx);
  endtask

  task automatic aborted();
    abort = 1'b1;
    start = 1'b0;
    @(negedge clk);
    abort = 1'b0;
    idle_chk("abort");
  endtask

  task automatic async_rst();
    #1 rst = 1'b0;
    #1;
    chk("arst_valid", sample_valid, 0);
    chk("arst_mrst", model_rst, 1);
    chk("arst_idx", cfg_idx, 0);
    chk("arst_busy", busy, 0);
    chk("arst_sdata", sample_data, 0);
    chk("arst_sidx", sample_idx, 0);
    chk("arst_gmin", g_min, 0);
    chk("arst_gmax", g_max, 0);
    start = 1'b0;
    sample_ready = 1'b0;
    mn = 0;
    mx = 0;
    seen = 0;
    #1 rst = 1'b1;
    @(negedge clk);
    idle_chk("arst_after");
  endtask

  // mode: 0 random ready, 1 ready high, 2 ready low 5 cycles
  // ab_ph: 0 RESET, 1 SETTLE, 2 WAIT+handshake, 3 rst, 4 start+abort
  task automatic sweep(int n, int s, int mode, int ab_cfg, int ab_ph);
    int exp_d;
    bit r;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_mrst", model_rst, 1);
    start = 1'b1;
    abort = (ab_ph == 4);
    cfg_count = CW'(n);
    settle_cycles = SW'(s);
    seen = 0;
    @(negedge clk);
    abort = 1'b0;
    if (n == 0) begin
      chk("z_done", done, 1);
      chk("z_busy", busy, 0);
      chk("z_mrst", model_rst, 1);
      chk("z_valid", sample_valid, 0);
      start = 1'b0;
      @(negedge clk);
      idle_chk("z_after");
      return;
    end
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < RC; i++) begin
        chk("rst_mrst", model_rst, 1);
        chk("rst_busy", busy, 1);
        chk("rst_idx", cfg_idx, k);
        chk("rst_valid", sample_valid, 0);
        chk("rst_done", done, 0);
        g_in = GW'($urandom);
        if (k == ab_cfg && ab_ph == 0 && i == 1) begin
          aborted();
          return;
        end
        @(negedge clk);
      end
      for (int i = 0; i <= s; i++) begin
        chk("set_mrst", model_rst, 0);
        chk("set_busy", busy, 1);
        chk("set_idx", cfg_idx, k);
        chk("set_valid", sample_valid, 0);
        if (i == s && gq.size() > 0) g_in = GW'(gq.pop_front());
        else g_in = GW'($urandom);
        exp_d = int'(g_in);
        if (k == ab_cfg && ab_ph == 1 && i == 0) begin
          aborted();
          return;
        end
        @(negedge clk);
      end
      for (int w = 0; w < 64; w++) begin
        chk("w_valid", sample_valid, 1);
        chk("w_data", sample_data, exp_d);
        chk("w_sidx", sample_idx, k);
        chk("w_idx", cfg_idx, k);
        chk("w_mrst", model_rst, 0);
        chk("w_busy", busy, 1);
        g_in = GW'($urandom);
        if (k == ab_cfg && ab_ph == 3) begin
          async_rst();
          return;
        end
        case (mode)
          1: r = 1'b1;
          2: r = (w >= 5);
          default: r = (w >= 6) || ($urandom_range(0, 2) == 0);
        endcase
        sample_ready = r;
        if (k == ab_cfg && ab_ph == 2) begin
          sample_ready = 1'b1;
          aborted();
          sample_ready = 1'b0;
          return;
        end
        @(negedge clk);
        if (r) begin
          mn = (!seen || exp_d < mn) ? exp_d : mn;
          mx = (!seen || exp_d > mx) ? exp_d : mx;
          seen = 1;
          sample_ready = 1'b0;
          break;
        end
      end
    end
    chk("d_done", done, 1);
    chk("d_busy", busy, 0);
    chk("d_mrst", model_rst, 1);
    chk("d_valid", sample_valid, 0);
    chk("d_gmin", g_min, mn);
    chk("d_gmax", g_max, mx);
    start = 1'b0;
    @(negedge clk);
    idle_chk("d_after");
  endtask

  initial begin
    #2;
    chk("r_mrst", model_rst, 1);
    chk("r_idx", cfg_idx, 0);
    chk("r_busy", busy, 0);
    chk("r_done", done, 0);
    chk("r_valid", sample_valid, 0);
    chk("r_sdata", sample_data, 0);
    chk("r_sidx", sample_idx, 0);
    chk("r_gmin", g_min, 0);
    chk("r_gmax", g_max, 0);
    #10 rst = 1'b1;
    sweep(2, 3, 1, -1, -1);
    sweep(2, 3, 2, -1, -1);
    sweep(0, 3, 1, -1, -1);
    gq = '{-100, 250, 0};
    sweep(3, 2, 1, -1, -1);
    chk("mm_min", g_min, -100);
    chk("mm_max", g_max, 250);
    sweep(3, 2, 1, 1, 1);
    sweep(3, 1, 1, 1, 2);
    sweep(3, 2, 0, 1, 0);
    sweep(2, 2, 1, 1, 3);
    sweep(2, 0, 0, -1, 4);
    sweep(15, 0, 1, -1, -1);
    for (int t = 0; t < 6; t++)
      sweep($urandom_range(1, 5), $urandom_range(0, 6), 0, -1, -1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
